uart_bus_bridge: RTL and testbench



---
 rtl/uart_bus_bridge_pkg.sv | 38 +++
 rtl/uart_bus_bridge_phy.sv | 104 ++++++++++
 rtl/uart_bus_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bus_bridge_pkg.sv
// Shared constants, state encoding and bus payload type for the UART debug bridge.
package sc64;

    localparam int unsigned CLOCK_FREQUENCY = 100_000_000;
    localparam int unsigned UART_BAUD_RATE  = 1_000_000;

    localparam logic [7:0] BRIDGE_OP_WRITE = 8'h57;
    localparam logic [7:0] BRIDGE_OP_READ  = 8'h52;
    localparam logic [7:0] BRIDGE_ACK      = 8'h06;
    localparam logic [7:0] BRIDGE_NAK      = 8'h15;

    typedef logic [2:0] e_bridge_state;

    localparam e_bridge_state S_IDLE     = 3'd0;
    localparam e_bridge_state S_ADDR     = 3'd1;
    localparam e_bridge_state S_DATA     = 3'd2;
    localparam e_bridge_state S_BUS_REQ  = 3'd3;
    localparam e_bridge_state S_BUS_WAIT = 3'd4;
    localparam e_bridge_state S_RESP     = 3'd5;
    localparam e_bridge_state S_NAK      = 3'd6;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } bus_req_t;

    // Big-endian byte pick: index 0 is the most significant byte.
    function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    return word[31:24];
            2'd1:    return word[23:16];
            2'd2:    return word[15:8];
            default: return word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/uart_bus_bridge_phy.sv
// 8N1 UART serializer/deserializer with a byte-wide strobe interface.
module uart_phy #(
    parameter int BAUD_GEN_VALUE = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
);

    localparam int unsigned CW = $clog2(BAUD_GEN_VALUE + 1);
    localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_GEN_VALUE);
    localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_GEN_VALUE / 2);

    logic          rxd_meta, rxd_sync;
    logic          rx_busy, rx_hold;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_shift;

    logic [8:0]    tx_shift;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_left;

    // Receiver: mid-bit sampling; after a bad stop bit wait for the line to go high again.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rx_busy  <= 1'b0;
            rx_hold  <= 1'b0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rx_valid <= 1'b0;
            if (!rx_busy) begin
                if (rx_hold) begin
                    if (rxd_sync) rx_hold <= 1'b0;
                end else if (!rxd_sync) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= BAUD_HALF;
                    rx_bit  <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - CW'(1);
            end else begin
                rx_cnt <= BAUD_FULL;
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0) begin
                    if (rxd_sync) rx_busy <= 1'b0;
                end else if (rx_bit == 4'd9) begin
                    rx_busy <= 1'b0;
                    if (rxd_sync) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                    end else begin
                        rx_hold <= 1'b1;
                    end
                end else begin
                    rx_shift <= {rxd_sync, rx_shift[7:1]};
                end
            end
        end
    end

    // Transmitter: start bit driven on accept, then data LSB first and the stop bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            uart_txd <= 1'b1;
            tx_ready <= 1'b1;
            tx_shift <= '1;
            tx_cnt   <= '0;
            tx_left  <= '0;
        end else if (tx_ready) begin
            if (tx_valid) begin
                uart_txd <= 1'b0;
                tx_shift <= {1'b1, tx_data};
                tx_cnt   <= BAUD_FULL;
                tx_left  <= 4'd9;
                tx_ready <= 1'b0;
            end
        end else if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - CW'(1);
        end else if (tx_left == 4'd0) begin
            tx_ready <= 1'b1;
        end else begin
            uart_txd <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[8:1]};
            tx_left  <= tx_left - 4'd1;
            tx_cnt   <= BAUD_FULL;
        end
    end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART-to-CPU-bus debug bridge: 'W'/'R' command frames become single-word bus transactions.
// Optional bus ack timeout enabled by defining UART_BRIDGE_TIMEOUT_EN.
module uart_bus_bridge
    import sc64::*;
#(
    parameter int BAUD_GEN_VALUE = int'(sc64::CLOCK_FREQUENCY / sc64::UART_BAUD_RATE) - 1
`ifdef UART_BRIDGE_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic        clk,
    input  logic        reset,
    output logic        bus_request,
    output logic [31:0] bus_address,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wmask,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        active
);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data_c;
    logic       tx_valid_c;
    logic       tx_ready;

    uart_phy #(.BAUD_GEN_VALUE(BAUD_GEN_VALUE)) u_phy (
        .clk      (clk),
        .reset    (reset),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data_c),
        .tx_valid (tx_valid_c),
        .tx_ready (tx_ready)
    );

    e_bridge_state state, state_d;
    logic [1:0]    byte_cnt, byte_cnt_d;
    logic [2:0]    resp_cnt, resp_cnt_d;
    logic          is_write, is_write_d;
    logic [23:0]   addr_q, addr_d;
    logic [23:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    bus_req_t      bus_q, bus_d;
    logic          request_d, active_d;

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_cnt, tmo_d;
`endif

    assign bus_address = bus_q.address;
    assign bus_wdata   = bus_q.wdata;
    assign bus_wmask   = bus_q.wmask;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            byte_cnt    <= '0;
            resp_cnt    <= '0;
            is_write    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            bus_q       <= '0;
            bus_request <= 1'b0;
            active      <= 1'b0;
`ifdef UART_BRIDGE_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            state       <= state_d;
            byte_cnt    <= byte_cnt_d;
            resp_cnt    <= resp_cnt_d;
            is_write    <= is_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            bus_q       <= bus_d;
            bus_request <= request_d;
            active      <= active_d;
`ifdef UART_BRIDGE_TIMEOUT_EN
            tmo_cnt     <= tmo_d;
`endif
        end
    end

    // Command parsing, bus handshake and response sequencing.
    always_comb begin
        state_d    = state;
        byte_cnt_d = byte_cnt;
        resp_cnt_d = resp_cnt;
        is_write_d = is_write;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        bus_d      = bus_q;
        request_d  = 1'b0;
        active_d   = active;
        tx_valid_c = 1'b0;
        tx_data_c  = 8'h00;
`ifdef UART_BRIDGE_TIMEOUT_EN
        tmo_d      = tmo_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == BRIDGE_OP_WRITE || rx_data == BRIDGE_OP_READ) begin
                        state_d    = S_ADDR;
                        byte_cnt_d = 2'd0;
                        is_write_d = (rx_data == BRIDGE_OP_WRITE);
                        active_d   = 1'b1;
                    end else begin
                        state_d    = S_NAK;
                        resp_cnt_d = 3'd0;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    addr_d     = {addr_q[15:0], rx_data};
                    byte_cnt_d = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        bus_d.address = {addr_q, rx_data[7:2], 2'b00};
                        if (is_write) begin
                            state_d = S_DATA;
                        end else begin
                            state_d     = S_BUS_REQ;
                            request_d   = 1'b1;
                            bus_d.wmask = 4'h0;
                        end
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    wdata_d    = {wdata_q[15:0], rx_data};
                    byte_cnt_d = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        bus_d.wdata = {wdata_q, rx_data};
                        bus_d.wmask = 4'hF;
                        state_d     = S_BUS_REQ;
                        request_d   = 1'b1;
                    end
                end
            end
            S_BUS_REQ: begin
                state_d = S_BUS_WAIT;
`ifdef UART_BRIDGE_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_BUS_WAIT: begin
                if (bus_ack) begin
                    if (!is_write) rdata_d = bus_rdata;
                    state_d    = S_RESP;
                    resp_cnt_d = 3'd0;
                end
`ifdef UART_BRIDGE_TIMEOUT_EN
                else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = S_NAK;
                    resp_cnt_d = 3'd0;
                end else begin
                    tmo_d = tmo_cnt + TW'(1);
                end
`endif
            end
            // Stay here until the final stop bit has gone out so active covers the whole reply.
            S_RESP: begin
                if (tx_ready) begin
                    if (resp_cnt == (is_write ? 3'd1 : 3'd4)) begin
                        state_d  = S_IDLE;
                        active_d = 1'b0;
                    end else begin
                        tx_valid_c = 1'b1;
                        tx_data_c  = is_write ? BRIDGE_ACK : be_byte(rdata_q, resp_cnt[1:0]);
                        resp_cnt_d = resp_cnt + 3'd1;
                    end
                end
            end
            S_NAK: begin
                if (tx_ready) begin
                    if (resp_cnt != 3'd0) begin
                        state_d  = S_IDLE;
                        active_d = 1'b0;
                    end else begin
                        tx_valid_c = 1'b1;
                        tx_data_c  = BRIDGE_NAK;
                        resp_cnt_d = 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed plus randomized frame bench for uart_bus_bridge with a UART line model and bus responder.
module tb_uart_bus_bridge;

    localparam int BIT_CLKS = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_request;
    logic [31:0] bus_address;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        uart_rxd;
    logic        uart_txd;
    logic        active;

    always #5 clk = ~clk;

    uart_bus_bridge #(.BAUD_GEN_VALUE(BIT_CLKS - 1)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_request (bus_request),
        .bus_address (bus_address),
        .bus_wdata   (bus_wdata),
        .bus_wmask   (bus_wmask),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .uart_rxd    (uart_rxd),
        .uart_txd    (uart_txd),
        .active      (active)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  tx_q[$];
    int          tx_stop_err = 0;
    logic [7:0]  mon_b;
    int          req_cnt = 0;
    int          req_long = 0;
    logic [31:0] cap_addr, cap_wdata, ack_addr, ack_wdata;
    logic [3:0]  cap_wmask;
    logic [31:0] next_rdata = 32'h0;
    int          ack_delay = 1;
    bit          withhold = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        uart_rxd = 1'b0;
        tick(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            tick(BIT_CLKS);
        end
        uart_rxd = stop_ok;
        tick(BIT_CLKS);
        uart_rxd = 1'b1;
        if (!stop_ok) tick(BIT_CLKS);
    endtask

    task automatic send_frame(input bit is_wr, input logic [31:0] addr, input logic [31:0] data);
        send_byte(is_wr ? 8'h57 : 8'h52, 1'b1);
        for (int k = 3; k >= 0; k--) send_byte(8'((addr >> (8 * k)) & 32'hFF), 1'b1);
        if (is_wr)
            for (int k = 3; k >= 0; k--) send_byte(8'((data >> (8 * k)) & 32'hFF), 1'b1);
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && tx_q.size() < n; i++) tick(1);
        check(tag, 32'(tx_q.size() >= n), 32'd1);
        tick(24);
    endtask

    function automatic logic [7:0] pop_byte();
        if (tx_q.size() == 0) return 8'hxx;
        return tx_q.pop_front();
    endfunction

    // Reference decode of uart_txd: 8N1, LSB first, sampled mid-bit.
    initial begin
        forever begin
            @(negedge clk);
            if (uart_txd === 1'b0) begin
                repeat (BIT_CLKS / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    mon_b[i] = uart_txd;
                end
                repeat (BIT_CLKS) @(negedge clk);
                if (uart_txd !== 1'b1) tx_stop_err++;
                tx_q.push_back(mon_b);
            end
        end
    end

    // Bus target: acks ack_delay cycles after the request unless withheld.
    initial begin
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_request === 1'b1 && reset === 1'b0) begin
                req_cnt++;
                cap_addr  = bus_address;
                cap_wdata = bus_wdata;
                cap_wmask = bus_wmask;
                tick(1);
                if (bus_request !== 1'b0) req_long++;
                if (!withhold) begin
                    if (ack_delay > 1) tick(ack_delay - 1);
                    bus_ack   = 1'b1;
                    bus_rdata = next_rdata;
                    ack_addr  = bus_address;
                    ack_wdata = bus_wdata;
                    tick(1);
                    bus_ack   = 1'b0;
                    bus_rdata = $urandom;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          r0;
        bit          is_wr;
        logic [31:0] addr, data, rd;

        uart_rxd = 1'b1;
        reset    = 1'b1;
        tick(5);
        check("rst_txd",     32'(uart_txd),    32'd1);
        check("rst_request", 32'(bus_request), 32'd0);
        check("rst_address", bus_address,      32'h0);
        check("rst_wdata",   bus_wdata,        32'h0);
        check("rst_wmask",   32'(bus_wmask),   32'h0);
        check("rst_active",  32'(active),      32'd0);
        reset = 1'b0;
        tick(5);

        // Directed write
        r0 = req_cnt;
        ack_delay = 2;
        send_byte(8'h57, 1'b1);
        check("wr_active_mid", 32'(active), 32'd1);
        foreach (addr[i]) addr[i] = 1'b0;
        addr = 32'h0000_1004;
        for (int k = 3; k >= 0; k--) send_byte(8'((addr >> (8 * k)) & 32'hFF), 1'b1);
        data = 32'hDEAD_BEEF;
        for (int k = 3; k >= 0; k--) send_byte(8'((data >> (8 * k)) & 32'hFF), 1'b1);
        wait_tx(1, 3000, "wr_resp_arrived");
        check("wr_resp",     32'(pop_byte()),  32'h06);
        check("wr_req_cnt",  32'(req_cnt - r0), 32'd1);
        check("wr_addr",     cap_addr,         32'h0000_1004);
        check("wr_wdata",    cap_wdata,        32'hDEAD_BEEF);
        check("wr_wmask",    32'(cap_wmask),   32'hF);
        check("wr_addr_held", ack_addr,        32'h0000_1004);
        check("wr_data_held", ack_wdata,       32'hDEAD_BEEF);
        check("wr_active_end", 32'(active),    32'd0);

        // Directed read with low address bits set
        r0 = req_cnt;
        ack_delay  = 3;
        next_rdata = 32'h1234_5678;
        send_frame(1'b0, 32'h0000_000B, 32'h0);
        wait_tx(4, 3000, "rd_resp_arrived");
        for (int k = 0; k < 4; k++)
            check($sformatf("rd_byte%0d", k), 32'(pop_byte()), (32'h1234_5678 >> (24 - 8 * k)) & 32'hFF);
        check("rd_req_cnt", 32'(req_cnt - r0), 32'd1);
        check("rd_addr",    cap_addr,          32'h0000_0008);
        check("rd_wmask",   32'(cap_wmask),    32'h0);
        check("rd_active_end", 32'(active),    32'd0);

        // Unknown opcode
        r0 = req_cnt;
        send_byte(8'h41, 1'b1);
        check("nak_active_mid", 32'(active), 32'd0);
        wait_tx(1, 1000, "nak_arrived");
        check("nak_resp",    32'(pop_byte()),   32'h15);
        check("nak_req_cnt", 32'(req_cnt - r0), 32'd0);
        check("nak_active",  32'(active),       32'd0);

        // Framing error on the opcode byte
        r0 = req_cnt;
        send_byte(8'h52, 1'b0);
        tick(300);
        check("ferr_no_tx",   32'(tx_q.size()),  32'd0);
        check("ferr_active",  32'(active),       32'd0);
        check("ferr_req_cnt", 32'(req_cnt - r0), 32'd0);
        rd = $urandom;
        next_rdata = rd;
        ack_delay  = 1;
        send_frame(1'b0, 32'h0000_0100, 32'h0);
        wait_tx(4, 3000, "ferr_rd_arrived");
        for (int k = 0; k < 4; k++)
            check($sformatf("ferr_rd_byte%0d", k), 32'(pop_byte()), (rd >> (24 - 8 * k)) & 32'hFF);

        // Reset in the middle of a frame
        r0 = req_cnt;
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        reset = 1'b1;
        tick(2);
        check("mrst_txd",     32'(uart_txd),    32'd1);
        check("mrst_request", 32'(bus_request), 32'd0);
        check("mrst_active",  32'(active),      32'd0);
        reset = 1'b0;
        tick(400);
        check("mrst_no_tx",   32'(tx_q.size()),  32'd0);
        check("mrst_req_cnt", 32'(req_cnt - r0), 32'd0);
        rd = $urandom;
        next_rdata = rd;
        send_frame(1'b0, 32'hA000_0014, 32'h0);
        wait_tx(4, 3000, "mrst_rd_arrived");
        for (int k = 0; k < 4; k++)
            check($sformatf("mrst_rd_byte%0d", k), 32'(pop_byte()), (rd >> (24 - 8 * k)) & 32'hFF);
        check("mrst_rd_addr", cap_addr, 32'hA000_0014);

        // Randomized frames against the reference expectations
        for (int n = 0; n < 8; n++) begin
            r0 = req_cnt;
            is_wr = 1'($urandom_range(0, 1));
            addr  = $urandom;
            data  = $urandom;
            rd    = $urandom;
            next_rdata = rd;
            ack_delay  = int'($urandom_range(1, 8));
            send_frame(is_wr, addr, data);
            wait_tx(is_wr ? 1 : 4, 3000, $sformatf("rnd%0d_arrived", n));
            check($sformatf("rnd%0d_req_cnt", n), 32'(req_cnt - r0), 32'd1);
            check($sformatf("rnd%0d_addr", n), cap_addr, addr & ~32'h3);
            check($sformatf("rnd%0d_wmask", n), 32'(cap_wmask), is_wr ? 32'hF : 32'h0);
            if (is_wr) begin
                check($sformatf("rnd%0d_wdata", n), cap_wdata, data);
                check($sformatf("rnd%0d_ack", n), 32'(pop_byte()), 32'h06);
            end else begin
                for (int k = 0; k < 4; k++)
                    check($sformatf("rnd%0d_rd_byte%0d", n, k), 32'(pop_byte()), (rd >> (24 - 8 * k)) & 32'hFF);
            end
            check($sformatf("rnd%0d_active", n), 32'(active), 32'd0);
        end

`ifdef UART_BRIDGE_TIMEOUT_EN
        // Withheld ack: NAK after the timeout, then a late ack has no effect
        r0 = req_cnt;
        withhold = 1'b1;
        send_frame(1'b0, 32'h0000_2000, 32'h0);
        tick(1000);
        check("tmo_no_early_tx", 32'(tx_q.size()), 32'd0);
        wait_tx(1, 1000, "tmo_nak_arrived");
        check("tmo_nak",     32'(pop_byte()),   32'h15);
        check("tmo_req_cnt", 32'(req_cnt - r0), 32'd1);
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        tick(1);
        bus_ack   = 1'b0;
        tick(300);
        check("tmo_late_no_tx", 32'(tx_q.size()), 32'd0);
        check("tmo_active",     32'(active),      32'd0);
        withhold = 1'b0;
        rd = $urandom;
        next_rdata = rd;
        send_frame(1'b0, 32'h0000_2004, 32'h0);
        wait_tx(4, 3000, "tmo_next_arrived");
        for (int k = 0; k < 4; k++)
            check($sformatf("tmo_next_byte%0d", k), 32'(pop_byte()), (rd >> (24 - 8 * k)) & 32'hFF);
`endif

        check("tx_stop_bits",    32'(tx_stop_err),  32'd0);
        check("request_one_cyc", 32'(req_long),     32'd0);
        check("no_extra_tx",     32'(tx_q.size()),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
